rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: ALU result (A) and memory load (M).
- Arbitrates with round-robin priority and a valid/ready handshake per requester.
- Drives the write port from registers.
- Keeps a per-register busy scoreboard so the issue logic can stall on pending writes.

---
 rtl/rf_write_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Shares the register file's single write port between two writeback
// requesters: the ALU result (A) and the memory load (M). Grants are
// round-robin under contention. The accepted request is registered onto
// the write port one cycle later. A per-register busy scoreboard lets the
// issue logic stall on writes that are still pending.
//
// Optional feature, enabled by defining RF_WRITE_BYPASS_EN:
//   - adds fwd_valid / fwd_addr / fwd_data, mirroring the write port so
//     readers can forward the value being written this cycle;
//   - busy[i] reads 0 while register i is being written, unless it is
//     being re-reserved in the same cycle.
// With the macro undefined, busy reflects registered state only.

module rf_write_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,

  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [ADDR_W-1:0]      m_addr,
  input  logic [DATA_W-1:0]      m_data,

  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic [(2**ADDR_W)-1:0] busy,

  output logic                   rf_write,
  output logic [ADDR_W-1:0]      rf_wr_addr,
  output logic [DATA_W-1:0]      rf_wr_data,

  output logic                   addr_err,
  output logic                   rsv_err
`ifdef RF_WRITE_BYPASS_EN
  ,
  output logic                   fwd_valid,
  output logic [ADDR_W-1:0]      fwd_addr,
  output logic [DATA_W-1:0]      fwd_data
`endif
);

  // One scoreboard bit per encodable address, implemented or not, so an
  // out-of-range write can still clear whatever was reserved there.
  localparam int NREG_ALL = 2**ADDR_W;

  // Round-robin turn: who wins the next contended cycle.
  localparam logic TURN_A = 1'b0;
  localparam logic TURN_M = 1'b1;

  // Address limit, sized one bit wider than the address so NUM_REGS == 2**ADDR_W fits.
  localparam logic [ADDR_W:0] REG_LIMIT = NUM_REGS[ADDR_W:0];

  logic                turn_q;

  logic                a_grant;
  logic                m_grant;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_in_range;

  // Address of the write accepted last cycle; its busy bit clears at the
  // end of the cycle in which it is presented on the port.
  logic                pend_q;
  logic [ADDR_W-1:0]   pend_addr_q;

  logic [NREG_ALL-1:0] busy_q;
  logic [NREG_ALL-1:0] set_mask;
  logic [NREG_ALL-1:0] clr_mask;
  logic [NREG_ALL-1:0] busy_next;

  // Grant: a lone requester always wins, contention is settled by the turn.
  always_comb begin
    a_grant = 1'b0;
    m_grant = 1'b0;
    if (a_valid && m_valid) begin
      if (turn_q == TURN_A) begin
        a_grant = 1'b1;
      end else begin
        m_grant = 1'b1;
      end
    end else if (a_valid) begin
      a_grant = 1'b1;
    end else if (m_valid) begin
      m_grant = 1'b1;
    end
  end

  assign a_ready = a_grant;
  assign m_ready = m_grant;
  assign accept  = a_grant | m_grant;

  // Mux the winning request and classify its address.
  always_comb begin
    sel_addr = a_addr;
    sel_data = a_data;
    if (m_grant) begin
      sel_addr = m_addr;
      sel_data = m_data;
    end
    sel_in_range = ({1'b0, sel_addr} < REG_LIMIT);
  end

  // Turn advances only when both requested, so a lone requester never
  // steals the other's next contended slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_q <= TURN_A;
    end else if (a_valid && m_valid) begin
      turn_q <= (turn_q == TURN_A) ? TURN_M : TURN_A;
    end
  end

  // Write port register: one-cycle accept latency; address/data hold when idle
  // and when the accepted address was out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      addr_err   <= 1'b0;
    end else begin
      rf_write <= accept && sel_in_range;
      addr_err <= accept && !sel_in_range;
      if (accept && sel_in_range) begin
        rf_wr_addr <= sel_addr;
        rf_wr_data <= sel_data;
      end
    end
  end

  // Track the accepted address separately from the port so out-of-range
  // writes still retire their scoreboard bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pend_q <= accept;
      if (accept) begin
        pend_addr_q <= sel_addr;
      end
    end
  end

  // Scoreboard set/clear masks; set is applied after clear so it wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NREG_ALL; i++) begin
      set_mask[i] = rsv_valid && (rsv_addr == i[ADDR_W-1:0]);
      clr_mask[i] = pend_q && (pend_addr_q == i[ADDR_W-1:0]);
    end
    busy_next = (busy_q & ~clr_mask) | set_mask;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  // Double reservation is flagged against the registered scoreboard; there
  // is no pending count, so the bit simply stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsv_err <= 1'b0;
    end else begin
      rsv_err <= rsv_valid && busy_q[rsv_addr];
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  logic [NREG_ALL-1:0] wr_mask;

  // Mask the bit being written this cycle unless it is being re-reserved.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NREG_ALL; i++) begin
      wr_mask[i] = rf_write && (rf_wr_addr == i[ADDR_W-1:0]);
    end
  end

  assign busy      = busy_q & ~(wr_mask & ~set_mask);
  assign fwd_valid = rf_write;
  assign fwd_addr  = rf_wr_addr;
  assign fwd_data  = rf_wr_data;
`else
  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// a randomized run against a cycle-level reference model.
module tb_rf_write_arbiter;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NB       = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_valid = 1'b0, m_valid = 1'b0, rsv_valid = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, m_addr = '0, rsv_addr = '0;
  logic [DATA_W-1:0] a_data = '0, m_data = '0;
  logic              a_ready, m_ready;
  logic [NB-1:0]     busy;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              addr_err, rsv_err;
`ifdef RF_WRITE_BYPASS_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy),
    .rf_write(rf_write), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .addr_err(addr_err), .rsv_err(rsv_err)
`ifdef RF_WRITE_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  // Reset with all inputs idle; released on a falling edge.
  task automatic do_reset();
    a_valid = 0; m_valid = 0; rsv_valid = 0;
    a_addr = 0; m_addr = 0; rsv_addr = 0; a_data = 0; m_data = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_valid = 0; m_valid = 0; rsv_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({rf_write, rf_wr_addr, rf_wr_data, addr_err, rsv_err} !== '0)
      $display("FAIL reset_port: got wr=%b addr=%0d data=%h aerr=%b rerr=%b want all 0",
               rf_write, rf_wr_addr, rf_wr_data, addr_err, rsv_err);
    else pass_cnt++;
    total_cnt++;
    if (busy !== '0) $display("FAIL reset_busy: got %b want 0", busy);
    else pass_cnt++;
    rst = 0;
  endtask

  task automatic test_single_write();
    do_reset();
    next_cycle();
    a_valid = 1; a_addr = 3'd2; a_data = 16'h1234;
    @(negedge clk);
    total_cnt++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0 || rf_write !== 1'b0)
      $display("FAIL single_accept: got a_ready=%b m_ready=%b wr=%b want 1 0 0", a_ready, m_ready, rf_write);
    else pass_cnt++;
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (rf_write !== 1'b1 || rf_wr_addr !== 3'd2 || rf_wr_data !== 16'h1234)
      $display("FAIL single_port: got wr=%b addr=%0d data=%h want 1 2 1234", rf_write, rf_wr_addr, rf_wr_data);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rf_write !== 1'b0 || rf_wr_addr !== 3'd2 || rf_wr_data !== 16'h1234)
      $display("FAIL single_idle: got wr=%b addr=%0d data=%h want 0 2 1234", rf_write, rf_wr_addr, rf_wr_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic exp_a;
    logic [ADDR_W-1:0] exp_port;
    do_reset();
    next_cycle();
    a_valid = 1; a_addr = 3'd1; a_data = 16'h00A1;
    m_valid = 1; m_addr = 3'd3; m_data = 16'h00B3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_a = (k % 2 == 0);
      total_cnt++;
      if (a_ready !== exp_a || m_ready !== !exp_a)
        $display("FAIL alt_grant%0d: got a=%b m=%b want a=%b m=%b", k, a_ready, m_ready, exp_a, !exp_a);
      else pass_cnt++;
      if (k > 0) begin
        exp_port = (k % 2 == 1) ? 3'd1 : 3'd3;
        total_cnt++;
        if (rf_write !== 1'b1 || rf_wr_addr !== exp_port)
          $display("FAIL alt_port%0d: got wr=%b addr=%0d want 1 %0d", k, rf_write, rf_wr_addr, exp_port);
        else pass_cnt++;
      end
      next_cycle();
    end
    a_valid = 0; m_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (rf_write !== 1'b1 || rf_wr_addr !== 3'd3 || rf_wr_data !== 16'h00B3)
      $display("FAIL alt_last: got wr=%b addr=%0d data=%h want 1 3 00b3", rf_write, rf_wr_addr, rf_wr_data);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    next_cycle();
    rsv_valid = 1; rsv_addr = 3'd3;
    next_cycle();
    rsv_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 8'b0000_1000) $display("FAIL sb_set: got %b want 00001000", busy);
    else pass_cnt++;
    next_cycle();
    m_valid = 1; m_addr = 3'd3; m_data = 16'h3333;
    @(negedge clk);
    total_cnt++;
    if (m_ready !== 1'b1 || busy !== 8'b0000_1000)
      $display("FAIL sb_accept: got m_ready=%b busy=%b want 1 00001000", m_ready, busy);
    else pass_cnt++;
    next_cycle();
    m_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (rf_write !== 1'b1 || busy !== 8'b0000_1000)
      $display("FAIL sb_commit: got wr=%b busy=%b want 1 00001000", rf_write, busy);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (busy !== 8'b0) $display("FAIL sb_clear: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_addr_err();
    do_reset();
    next_cycle();
    rsv_valid = 1; rsv_addr = 3'd6;
    next_cycle();
    rsv_valid = 0;
    m_valid = 1; m_addr = 3'd6; m_data = 16'hBEEF;
    @(negedge clk);
    total_cnt++;
    if (m_ready !== 1'b1) $display("FAIL aerr_accept: got m_ready=%b want 1", m_ready);
    else pass_cnt++;
    next_cycle();
    m_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (rf_write !== 1'b0 || addr_err !== 1'b1 || busy !== 8'b0100_0000)
      $display("FAIL aerr_pulse: got wr=%b aerr=%b busy=%b want 0 1 01000000", rf_write, addr_err, busy);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (addr_err !== 1'b0 || busy !== 8'b0)
      $display("FAIL aerr_end: got aerr=%b busy=%b want 0 0", addr_err, busy);
    else pass_cnt++;
  endtask

  task automatic test_rsv_err();
    do_reset();
    next_cycle();
    a_valid = 1; a_addr = 3'd1; a_data = 16'h0101;
    next_cycle();
    a_valid = 0;
    rsv_valid = 1; rsv_addr = 3'd1;
    @(negedge clk);
    total_cnt++;
    if (rf_write !== 1'b1 || rf_wr_addr !== 3'd1)
      $display("FAIL rerr_commit: got wr=%b addr=%0d want 1 1", rf_write, rf_wr_addr);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (busy !== 8'b0000_0010 || rsv_err !== 1'b0)
      $display("FAIL rerr_setwins: got busy=%b rerr=%b want 00000010 0", busy, rsv_err);
    else pass_cnt++;
    next_cycle();
    rsv_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 8'b0000_0010 || rsv_err !== 1'b1)
      $display("FAIL rerr_pulse: got busy=%b rerr=%b want 00000010 1", busy, rsv_err);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total_cnt++;
    if (rsv_err !== 1'b0) $display("FAIL rerr_end: got %b want 0", rsv_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle();
    a_valid = 1; a_addr = 3'd2; a_data = 16'hCAFE;
    rsv_valid = 1; rsv_addr = 3'd2;
    next_cycle();
    a_valid = 0; rsv_valid = 0;
    total_cnt++;
    if (rf_write !== 1'b1 || busy !== 8'b0000_0100)
      $display("FAIL rmid_pre: got wr=%b busy=%b want 1 00000100", rf_write, busy);
    else pass_cnt++;
    #2 rst = 1;
    #1;
    total_cnt++;
    if (rf_write !== 1'b0 || busy !== 8'b0)
      $display("FAIL rmid_async: got wr=%b busy=%b want 0 0", rf_write, busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 0;
    next_cycle();
    m_valid = 1; m_addr = 3'd0; m_data = 16'h5A5A;
    @(negedge clk);
    total_cnt++;
    if (m_ready !== 1'b1 || a_ready !== 1'b0)
      $display("FAIL rmid_grant: got m_ready=%b a_ready=%b want 1 0", m_ready, a_ready);
    else pass_cnt++;
    next_cycle();
    m_valid = 0;
    @(negedge clk);
    total_cnt++;
    if (rf_write !== 1'b1 || rf_wr_addr !== 3'd0 || rf_wr_data !== 16'h5A5A)
      $display("FAIL rmid_port: got wr=%b addr=%0d data=%h want 1 0 5a5a", rf_write, rf_wr_addr, rf_wr_data);
    else pass_cnt++;
  endtask

  // Randomized run. The model tracks whose turn it is, the scoreboard as an
  // array of flags, and the expected port contents one cycle behind.
  task automatic test_random();
    bit                m_turn;
    bit                sb [NB];
    bit                e_wr, e_aerr, e_rerr;
    int                e_addr, e_data;
    bit                prev_acc;
    int                prev_addr;
    bit                ga, gm, nrerr;
    int                w_addr, w_data;
    logic [NB-1:0]     e_busy;
    int                errs_before;

    do_reset();
    m_turn = 0; e_wr = 0; e_aerr = 0; e_rerr = 0; e_addr = 0; e_data = 0;
    prev_acc = 0; prev_addr = 0;
    for (int i = 0; i < NB; i++) sb[i] = 0;
    ga = 0; gm = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      next_cycle();
      if (ga || !a_valid) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = ADDR_W'($urandom_range(0, NB-1));
        a_data  = DATA_W'($urandom);
      end
      if (gm || !m_valid) begin
        m_valid = ($urandom_range(0, 2) != 0);
        m_addr  = ADDR_W'($urandom_range(0, NB-1));
        m_data  = DATA_W'($urandom);
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = ADDR_W'($urandom_range(0, NB-1));

      if (a_valid && m_valid) begin
        ga = !m_turn;
        gm = m_turn;
      end else begin
        ga = a_valid;
        gm = m_valid;
      end
      for (int i = 0; i < NB; i++) e_busy[i] = sb[i];

      @(negedge clk);
      errs_before = total_cnt - pass_cnt;
      total_cnt++;
      if (a_ready !== ga || m_ready !== gm)
        $display("FAIL rnd_grant c%0d: got a=%b m=%b want a=%b m=%b", cyc, a_ready, m_ready, ga, gm);
      else pass_cnt++;
      total_cnt++;
      if (rf_write !== e_wr || addr_err !== e_aerr || rsv_err !== e_rerr)
        $display("FAIL rnd_flags c%0d: got wr=%b aerr=%b rerr=%b want %b %b %b",
                 cyc, rf_write, addr_err, rsv_err, e_wr, e_aerr, e_rerr);
      else pass_cnt++;
      total_cnt++;
      if (rf_wr_addr !== ADDR_W'(e_addr) || rf_wr_data !== DATA_W'(e_data))
        $display("FAIL rnd_port c%0d: got addr=%0d data=%h want %0d %h",
                 cyc, rf_wr_addr, rf_wr_data, e_addr, DATA_W'(e_data));
      else pass_cnt++;
      total_cnt++;
      if (busy !== e_busy)
        $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, e_busy);
      else pass_cnt++;
      if (total_cnt - pass_cnt > errs_before + 20) break;

      // Advance the model across the coming rising edge.
      nrerr = rsv_valid && sb[rsv_addr];
      if (prev_acc) sb[prev_addr] = 0;
      if (rsv_valid) sb[rsv_addr] = 1;
      e_rerr = nrerr;
      w_addr = gm ? int'(m_addr) : int'(a_addr);
      w_data = gm ? int'(m_data) : int'(a_data);
      e_wr   = (ga || gm) && (w_addr < NUM_REGS);
      e_aerr = (ga || gm) && (w_addr >= NUM_REGS);
      if (e_wr) begin
        e_addr = w_addr;
        e_data = w_data;
      end
      prev_acc  = ga || gm;
      prev_addr = w_addr;
      if (a_valid && m_valid) m_turn = !m_turn;
    end
    a_valid = 0; m_valid = 0; rsv_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_scoreboard();
    test_addr_err();
    test_rsv_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
